// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback arbiter.
package wb_pkg;

    localparam int WB_ADDR_W = 5;
    localparam int WB_DATA_W = 32;
    localparam int NUM_REGS  = 2 ** WB_ADDR_W;
    localparam int REG_ZERO  = 0;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] dest;
        logic [WB_DATA_W-1:0] data;
    } wb_result_t;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_ALU  = 2'd1,
        SRC_MDU  = 2'd2
    } wb_src_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// Bus bundle between execute stages, issue stage, register file and the arbiter.
interface wb_arbiter_if #(
    parameter int DATA_W = wb_pkg::WB_DATA_W,
    parameter int ADDR_W = wb_pkg::WB_ADDR_W
);
    import wb_pkg::*;

    logic                   alu_valid;
    logic [ADDR_W-1:0]      alu_dest;
    logic [DATA_W-1:0]      alu_data;
    logic                   mdu_valid;
    logic [ADDR_W-1:0]      mdu_dest;
    logic [DATA_W-1:0]      mdu_data;
    logic                   mdu_ready;
    logic                   issue_valid;
    logic [ADDR_W-1:0]      issue_dest;
    logic [2**ADDR_W-1:0]   busy_mask;
    logic                   reg_write_en;
    logic [ADDR_W-1:0]      reg_write_dest;
    logic [DATA_W-1:0]      reg_write_data;
    logic                   err;

    // Producer side: execute/issue stages and register file consumer.
    modport master (
        output alu_valid, alu_dest, alu_data,
        output mdu_valid, mdu_dest, mdu_data,
        output issue_valid, issue_dest,
        input  mdu_ready, busy_mask, reg_write_en, reg_write_dest, reg_write_data, err
    );

    // Arbiter side.
    modport slave (
        input  alu_valid, alu_dest, alu_data,
        input  mdu_valid, mdu_dest, mdu_data,
        input  issue_valid, issue_dest,
        output mdu_ready, busy_mask, reg_write_en, reg_write_dest, reg_write_data, err
    );

endinterface

// File: rtl/wb_fifo.sv
// Synchronous FIFO holding MDU results waiting for the write port.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = WB_ADDR_W + WB_DATA_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    // Next pointer/count; pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU-priority merge of ALU and MDU results onto one
// register-file write port, with an MDU result FIFO and a busy scoreboard.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic         clk,
    input  logic         rst,
    wb_arbiter_if.slave  bus
);

    localparam int NREG = 2 ** ADDR_W;

    wb_src_t              src;
    logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [ADDR_W+DATA_W-1:0] fifo_head;
    logic [ADDR_W-1:0]    head_dest, sel_dest;
    logic [DATA_W-1:0]    head_data, sel_data;
    logic                 mdu_xfer, mdu_drop, issue_err;
    logic [NREG-1:0]      set_mask, clr_mask;

    logic                 reg_write_en_q, reg_write_en_d;
    logic [ADDR_W-1:0]    reg_write_dest_q, reg_write_dest_d;
    logic [DATA_W-1:0]    reg_write_data_q, reg_write_data_d;
    logic [NREG-1:0]      busy_q, busy_d;
    logic                 err_q, err_d;

    wb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR_W + DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data ({bus.mdu_dest, bus.mdu_data}),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    assign {head_dest, head_data} = fifo_head;
    assign bus.mdu_ready = !fifo_full;
    assign mdu_xfer      = bus.mdu_valid && !fifo_full;
    assign mdu_drop      = bus.mdu_valid && fifo_full;

    // Source selection, FIFO control, scoreboard masks and next register values.
    always_comb begin
        src       = SRC_NONE;
        fifo_pop  = 1'b0;
        sel_dest  = '0;
        sel_data  = '0;
        if (bus.alu_valid) begin
            src      = SRC_ALU;
            sel_dest = bus.alu_dest;
            sel_data = bus.alu_data;
        end else if (!fifo_empty) begin
            src      = SRC_MDU;
            fifo_pop = 1'b1;
            sel_dest = head_dest;
            sel_data = head_data;
        end else if (mdu_xfer) begin
            src      = SRC_MDU;
            sel_dest = bus.mdu_dest;
            sel_data = bus.mdu_data;
        end
        // Only the bypass path (no ALU, empty FIFO) skips the enqueue.
        fifo_push = mdu_xfer && (bus.alu_valid || !fifo_empty);

        set_mask = '0;
        if (bus.issue_valid && bus.issue_dest != ADDR_W'(REG_ZERO))
            set_mask[bus.issue_dest] = 1'b1;
        clr_mask = '0;
        if (src == SRC_MDU && sel_dest != ADDR_W'(REG_ZERO))
            clr_mask[sel_dest] = 1'b1;
        busy_d = (busy_q & ~clr_mask) | set_mask;

        // A re-issue to a register whose result retires this very cycle is legal.
        issue_err = bus.issue_valid && bus.issue_dest != ADDR_W'(REG_ZERO)
                    && busy_q[bus.issue_dest] && !clr_mask[bus.issue_dest];
        err_d     = err_q || mdu_drop || issue_err;

        // Writes to register 0 are consumed but never reach the register file.
        reg_write_en_d   = (src != SRC_NONE) && (sel_dest != ADDR_W'(REG_ZERO));
        reg_write_dest_d = reg_write_en_d ? sel_dest : reg_write_dest_q;
        reg_write_data_d = reg_write_en_d ? sel_data : reg_write_data_q;
    end

    // Write-port, scoreboard and error registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_write_en_q   <= 1'b0;
            reg_write_dest_q <= '0;
            reg_write_data_q <= '0;
            busy_q           <= '0;
            err_q            <= 1'b0;
        end else begin
            reg_write_en_q   <= reg_write_en_d;
            reg_write_dest_q <= reg_write_dest_d;
            reg_write_data_q <= reg_write_data_d;
            busy_q           <= busy_d;
            err_q            <= err_d;
        end
    end

    assign bus.reg_write_en   = reg_write_en_q;
    assign bus.reg_write_dest = reg_write_dest_q;
    assign bus.reg_write_data = reg_write_data_q;
    assign bus.busy_mask      = busy_q;
    assign bus.err            = err_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed testbench for wb_arbiter.
module tb_wb_arbiter;
    import wb_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    wb_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    wb_arbiter #(.DEPTH(4), .DATA_W(32), .ADDR_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Advance one clock; inputs are changed and outputs sampled 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.alu_valid = 0; bus.alu_dest = '0; bus.alu_data = '0;
        bus.mdu_valid = 0; bus.mdu_dest = '0; bus.mdu_data = '0;
        bus.issue_valid = 0; bus.issue_dest = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.reg_write_en !== 1'b0) begin errors++; $display("FAIL reset_en: got %b want 0", bus.reg_write_en); end
        checks++; if (bus.reg_write_dest !== 5'd0) begin errors++; $display("FAIL reset_dest: got %0d want 0", bus.reg_write_dest); end
        checks++; if (bus.reg_write_data !== 32'd0) begin errors++; $display("FAIL reset_data: got %h want 0", bus.reg_write_data); end
        checks++; if (bus.busy_mask !== 32'd0) begin errors++; $display("FAIL reset_busy: got %h want 0", bus.busy_mask); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", bus.err); end
        checks++; if (bus.mdu_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.mdu_ready); end
    endtask

    task automatic test_alu();
        bus.alu_valid = 1; bus.alu_dest = 5'd3; bus.alu_data = 32'h1234;
        cyc();
        idle();
        checks++; if (bus.reg_write_en !== 1'b1) begin errors++; $display("FAIL alu_en: got %b want 1", bus.reg_write_en); end
        checks++; if (bus.reg_write_dest !== 5'd3) begin errors++; $display("FAIL alu_dest: got %0d want 3", bus.reg_write_dest); end
        checks++; if (bus.reg_write_data !== 32'h1234) begin errors++; $display("FAIL alu_data: got %h want 1234", bus.reg_write_data); end
        checks++; if (bus.busy_mask !== 32'd0) begin errors++; $display("FAIL alu_busy: got %h want 0", bus.busy_mask); end
        cyc();
        checks++; if (bus.reg_write_en !== 1'b0) begin errors++; $display("FAIL alu_idle_en: got %b want 0", bus.reg_write_en); end
        checks++; if (bus.reg_write_dest !== 5'd3 || bus.reg_write_data !== 32'h1234) begin errors++; $display("FAIL alu_hold: got %0d/%h want 3/1234", bus.reg_write_dest, bus.reg_write_data); end
    endtask

    task automatic test_bypass();
        bus.issue_valid = 1; bus.issue_dest = 5'd8;
        cyc();
        idle();
        checks++; if (bus.busy_mask !== 32'h100) begin errors++; $display("FAIL byp_busy_set: got %h want 100", bus.busy_mask); end
        bus.mdu_valid = 1; bus.mdu_dest = 5'd8; bus.mdu_data = 32'hA5A5A5A5;
        checks++; if (bus.mdu_ready !== 1'b1) begin errors++; $display("FAIL byp_ready: got %b want 1", bus.mdu_ready); end
        cyc();
        idle();
        checks++; if (bus.reg_write_en !== 1'b1 || bus.reg_write_dest !== 5'd8 || bus.reg_write_data !== 32'hA5A5A5A5) begin errors++; $display("FAIL byp_write: got %b/%0d/%h want 1/8/a5a5a5a5", bus.reg_write_en, bus.reg_write_dest, bus.reg_write_data); end
        checks++; if (bus.busy_mask !== 32'd0) begin errors++; $display("FAIL byp_busy_clr: got %h want 0", bus.busy_mask); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL byp_err: got %b want 0", bus.err); end
        cyc();
        checks++; if (bus.reg_write_en !== 1'b0) begin errors++; $display("FAIL byp_once: got %b want 0", bus.reg_write_en); end
    endtask

    task automatic test_priority_fill();
        for (int c = 0; c < 6; c++) begin
            idle();
            bus.alu_valid = 1; bus.alu_dest = 5'(20 + c); bus.alu_data = 32'h2000 + c;
            if (c < 5) begin
                bus.mdu_valid = 1; bus.mdu_dest = 5'(c + 1); bus.mdu_data = 32'h100 + c + 1;
            end
            checks++; if (bus.mdu_ready !== (c < 4)) begin errors++; $display("FAIL fill_ready c%0d: got %b want %b", c, bus.mdu_ready, (c < 4)); end
            cyc();
            checks++; if (bus.reg_write_en !== 1'b1 || bus.reg_write_dest !== 5'(20 + c) || bus.reg_write_data !== 32'h2000 + c) begin errors++; $display("FAIL fill_alu c%0d: got %b/%0d/%h want 1/%0d/%h", c, bus.reg_write_en, bus.reg_write_dest, bus.reg_write_data, 20 + c, 32'h2000 + c); end
            checks++; if (bus.err !== (c >= 4)) begin errors++; $display("FAIL fill_err c%0d: got %b want %b", c, bus.err, (c >= 4)); end
        end
        idle();
        for (int k = 1; k <= 4; k++) begin
            cyc();
            checks++; if (bus.reg_write_en !== 1'b1 || bus.reg_write_dest !== 5'(k) || bus.reg_write_data !== 32'h100 + k) begin errors++; $display("FAIL drain k%0d: got %b/%0d/%h want 1/%0d/%h", k, bus.reg_write_en, bus.reg_write_dest, bus.reg_write_data, k, 32'h100 + k); end
            checks++; if (bus.mdu_ready !== 1'b1) begin errors++; $display("FAIL drain_ready k%0d: got %b want 1", k, bus.mdu_ready); end
        end
        cyc();
        checks++; if (bus.reg_write_en !== 1'b0) begin errors++; $display("FAIL drain_done: got %b want 0", bus.reg_write_en); end
        checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", bus.err); end
        do_reset();
    endtask

    task automatic test_issue_err();
        bus.issue_valid = 1; bus.issue_dest = 5'd5;
        cyc();
        checks++; if (bus.err !== 1'b0 || bus.busy_mask !== 32'h20) begin errors++; $display("FAIL issue_first: got err=%b busy=%h want 0/20", bus.err, bus.busy_mask); end
        cyc();
        idle();
        checks++; if (bus.err !== 1'b1 || bus.busy_mask !== 32'h20) begin errors++; $display("FAIL issue_dup: got err=%b busy=%h want 1/20", bus.err, bus.busy_mask); end
        do_reset();
    endtask

    task automatic test_reg_zero();
        bus.alu_valid = 1; bus.alu_dest = 5'd0; bus.alu_data = 32'hDEAD;
        bus.mdu_valid = 1; bus.mdu_dest = 5'd0; bus.mdu_data = 32'hBEEF;
        bus.issue_valid = 1; bus.issue_dest = 5'd0;
        cyc();
        idle();
        checks++; if (bus.reg_write_en !== 1'b0) begin errors++; $display("FAIL r0_alu_en: got %b want 0", bus.reg_write_en); end
        checks++; if (bus.busy_mask !== 32'd0 || bus.err !== 1'b0) begin errors++; $display("FAIL r0_busy: got busy=%h err=%b want 0/0", bus.busy_mask, bus.err); end
        cyc();
        checks++; if (bus.reg_write_en !== 1'b0) begin errors++; $display("FAIL r0_mdu_en: got %b want 0", bus.reg_write_en); end
        // FIFO must now be empty, so a fresh MDU offer bypasses immediately.
        bus.mdu_valid = 1; bus.mdu_dest = 5'd7; bus.mdu_data = 32'h77;
        cyc();
        idle();
        checks++; if (bus.reg_write_en !== 1'b1 || bus.reg_write_dest !== 5'd7 || bus.reg_write_data !== 32'h77) begin errors++; $display("FAIL r0_drained: got %b/%0d/%h want 1/7/77", bus.reg_write_en, bus.reg_write_dest, bus.reg_write_data); end
    endtask

    task automatic test_same_cycle();
        bus.issue_valid = 1; bus.issue_dest = 5'd9;
        cyc();
        idle();
        bus.mdu_valid = 1; bus.mdu_dest = 5'd9; bus.mdu_data = 32'h99;
        bus.issue_valid = 1; bus.issue_dest = 5'd9;
        cyc();
        idle();
        checks++; if (bus.reg_write_en !== 1'b1 || bus.reg_write_dest !== 5'd9 || bus.reg_write_data !== 32'h99) begin errors++; $display("FAIL sc_write: got %b/%0d/%h want 1/9/99", bus.reg_write_en, bus.reg_write_dest, bus.reg_write_data); end
        checks++; if (bus.busy_mask !== 32'h200) begin errors++; $display("FAIL sc_busy: got %h want 200", bus.busy_mask); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL sc_err: got %b want 0", bus.err); end
        bus.mdu_valid = 1; bus.mdu_dest = 5'd9; bus.mdu_data = 32'h9A;
        cyc();
        idle();
        checks++; if (bus.busy_mask !== 32'd0) begin errors++; $display("FAIL sc_clear: got %h want 0", bus.busy_mask); end
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 3; c++) begin
            idle();
            bus.alu_valid = 1; bus.alu_dest = 5'd30; bus.alu_data = 32'h3000 + c;
            bus.mdu_valid = 1; bus.mdu_dest = 5'(11 + c); bus.mdu_data = 32'h1100 + c;
            if (c == 0) begin bus.issue_valid = 1; bus.issue_dest = 5'd11; end
            cyc();
        end
        idle();
        checks++; if (bus.busy_mask !== 32'h800 || bus.mdu_ready !== 1'b1) begin errors++; $display("FAIL rm_pre: got busy=%h ready=%b want 800/1", bus.busy_mask, bus.mdu_ready); end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        checks++; if (bus.reg_write_en !== 1'b0 || bus.reg_write_dest !== 5'd0 || bus.reg_write_data !== 32'd0) begin errors++; $display("FAIL rm_write: got %b/%0d/%h want 0/0/0", bus.reg_write_en, bus.reg_write_dest, bus.reg_write_data); end
        checks++; if (bus.busy_mask !== 32'd0 || bus.err !== 1'b0 || bus.mdu_ready !== 1'b1) begin errors++; $display("FAIL rm_state: got busy=%h err=%b ready=%b want 0/0/1", bus.busy_mask, bus.err, bus.mdu_ready); end
        for (int i = 0; i < 5; i++) begin
            cyc();
            checks++; if (bus.reg_write_en !== 1'b0) begin errors++; $display("FAIL rm_nowrite i%0d: got %b dest %0d want 0", i, bus.reg_write_en, bus.reg_write_dest); end
        end
    endtask

    initial begin
        idle();
        rst = 1'b1;
        repeat (3) cyc();
        rst = 1'b0;
        test_reset();
        test_alu();
        test_bypass();
        test_priority_fill();
        test_issue_err();
        test_reg_zero();
        test_same_cycle();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
